// File: rtl/pwm_regs_pkg.sv
// Shared definitions for the multi-channel PWM register bank.
//   - Register offsets within a channel's 16-byte window (addr[3:0]).
//   - STATUS bit positions, used only when PWM_REGS_IRQ_EN is defined.
//   - Reset value of the per-channel upnotdown bit.
//   - Byte-merge helper for the 16-bit shadowed registers.
package pwm_regs_pkg;

  localparam logic [3:0] OFF_PERIOD_L    = 4'h0;
  localparam logic [3:0] OFF_PERIOD_H    = 4'h1;
  localparam logic [3:0] OFF_EN          = 4'h2;
  localparam logic [3:0] OFF_CMP1_L      = 4'h3;
  localparam logic [3:0] OFF_CMP1_H      = 4'h4;
  localparam logic [3:0] OFF_CMP2_L      = 4'h5;
  localparam logic [3:0] OFF_CMP2_H      = 4'h6;
  localparam logic [3:0] OFF_COUNT_RESET = 4'h7;
  localparam logic [3:0] OFF_COUNTER_L   = 4'h8;
  localparam logic [3:0] OFF_COUNTER_H   = 4'h9;
  localparam logic [3:0] OFF_PRESCALE    = 4'hA;
  localparam logic [3:0] OFF_UPNOTDOWN   = 4'hB;
  localparam logic [3:0] OFF_PWM_EN      = 4'hC;
  localparam logic [3:0] OFF_FUNCTIONS   = 4'hD;
  localparam logic [3:0] OFF_STATUS      = 4'hE;
  localparam logic [3:0] OFF_IRQ_MASK    = 4'hF;

  localparam int unsigned ST_WRAP   = 0;
  localparam int unsigned ST_LOADED = 1;

  localparam logic UPNOTDOWN_RST = 1'b1;

  // Replace the low (hi=0) or high (hi=1) byte of a 16-bit value.
  function automatic logic [15:0] merge_byte(logic [15:0] val, logic hi, logic [7:0] b);
    logic [15:0] res;
    res = val;
    if (hi) res[15:8] = b;
    else    res[7:0]  = b;
    return res;
  endfunction

endpackage

// File: rtl/pwm_regs_ch.sv
// One channel of the PWM register bank.
// Holds shadow/active PERIOD, CMP1, CMP2 with a pending-transfer flag, the unshadowed
// control bytes, the one-cycle count_reset pulse, the counter high-byte snapshot and,
// when PWM_REGS_IRQ_EN is defined, the STATUS/IRQ_MASK pair.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, rd_en        this channel is the target of the current write / read
//   offset, wdata       register offset and write data
//   upd                 counter wrap pulse for this channel
//   counter_val         live counter value
//   period, compare1, compare2   active values
//   en, count_reset, upnotdown, pwm_en, prescale, functions   control outputs
//   irq_req             |(STATUS & IRQ_MASK), present only with PWM_REGS_IRQ_EN
//   rdata               combinational read mux for offset
module pwm_regs_ch
  import pwm_regs_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [3:0]       offset,
  input  logic [7:0]       wdata,
  input  logic             upd,
  input  logic [CNT_W-1:0] counter_val,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] compare1,
  output logic [CNT_W-1:0] compare2,
  output logic             en,
  output logic             count_reset,
  output logic             upnotdown,
  output logic             pwm_en,
  output logic [7:0]       prescale,
  output logic [7:0]       functions,
`ifdef PWM_REGS_IRQ_EN
  output logic             irq_req,
`endif
  output logic [7:0]       rdata
);

  logic [CNT_W-1:0] per_sh_q, per_sh_d, per_q, per_d;
  logic [CNT_W-1:0] cmp1_sh_q, cmp1_sh_d, cmp1_q, cmp1_d;
  logic [CNT_W-1:0] cmp2_sh_q, cmp2_sh_d, cmp2_q, cmp2_d;
  logic             pending_q, pending_d;
  logic             en_q, en_d, upnotdown_q, upnotdown_d, pwm_en_q, pwm_en_d;
  logic [7:0]       prescale_q, prescale_d, functions_q, functions_d;
  logic             count_reset_q;
  logic [7:0]       snap_q, snap_d;

  // 16-bit zero-extended views; bits above CNT_W-1 read as 0.
  logic [15:0] per16, cmp1_16, cmp2_16, cnt16, tmp16;

  logic wr_per, wr_cmp1, wr_cmp2, wr_shadow, wr_cnt_rst, xfer;

  always_comb begin
    per16   = '0;
    cmp1_16 = '0;
    cmp2_16 = '0;
    cnt16   = '0;
    per16[CNT_W-1:0]   = per_sh_q;
    cmp1_16[CNT_W-1:0] = cmp1_sh_q;
    cmp2_16[CNT_W-1:0] = cmp2_sh_q;
    cnt16[CNT_W-1:0]   = counter_val;
  end

  assign wr_per     = wr_en && (offset == OFF_PERIOD_L || offset == OFF_PERIOD_H);
  assign wr_cmp1    = wr_en && (offset == OFF_CMP1_L || offset == OFF_CMP1_H);
  assign wr_cmp2    = wr_en && (offset == OFF_CMP2_L || offset == OFF_CMP2_H);
  assign wr_shadow  = wr_per || wr_cmp1 || wr_cmp2;
  assign wr_cnt_rst = wr_en && (offset == OFF_COUNT_RESET);

  // A stopped channel loads as soon as it is pending; a COUNT_RESET write always loads.
  assign xfer = (pending_q && (upd || !en_q)) || wr_cnt_rst;

  always_comb begin
    per_sh_d    = per_sh_q;
    cmp1_sh_d   = cmp1_sh_q;
    cmp2_sh_d   = cmp2_sh_q;
    tmp16       = '0;
    en_d        = en_q;
    upnotdown_d = upnotdown_q;
    pwm_en_d    = pwm_en_q;
    prescale_d  = prescale_q;
    functions_d = functions_q;
    snap_d      = snap_q;

    if (wr_per) begin
      tmp16    = merge_byte(per16, offset == OFF_PERIOD_H, wdata);
      per_sh_d = tmp16[CNT_W-1:0];
    end
    if (wr_cmp1) begin
      tmp16     = merge_byte(cmp1_16, offset == OFF_CMP1_H, wdata);
      cmp1_sh_d = tmp16[CNT_W-1:0];
    end
    if (wr_cmp2) begin
      tmp16     = merge_byte(cmp2_16, offset == OFF_CMP2_H, wdata);
      cmp2_sh_d = tmp16[CNT_W-1:0];
    end
    if (wr_en && offset == OFF_EN)        en_d        = wdata[0];
    if (wr_en && offset == OFF_UPNOTDOWN) upnotdown_d = wdata[0];
    if (wr_en && offset == OFF_PWM_EN)    pwm_en_d    = wdata[0];
    if (wr_en && offset == OFF_PRESCALE)  prescale_d  = wdata;
    if (wr_en && offset == OFF_FUNCTIONS) functions_d = wdata;
    if (rd_en && offset == OFF_COUNTER_L) snap_d      = cnt16[15:8];

    // Active takes the pre-write shadow, so a colliding write stays pending.
    per_d  = xfer ? per_sh_q  : per_q;
    cmp1_d = xfer ? cmp1_sh_q : cmp1_q;
    cmp2_d = xfer ? cmp2_sh_q : cmp2_q;
    if (wr_shadow) pending_d = 1'b1;
    else if (xfer) pending_d = 1'b0;
    else           pending_d = pending_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_sh_q      <= '0;
      cmp1_sh_q     <= '0;
      cmp2_sh_q     <= '0;
      per_q         <= '0;
      cmp1_q        <= '0;
      cmp2_q        <= '0;
      pending_q     <= 1'b0;
      en_q          <= 1'b0;
      upnotdown_q   <= UPNOTDOWN_RST;
      pwm_en_q      <= 1'b0;
      prescale_q    <= '0;
      functions_q   <= '0;
      count_reset_q <= 1'b0;
      snap_q        <= '0;
    end else begin
      per_sh_q      <= per_sh_d;
      cmp1_sh_q     <= cmp1_sh_d;
      cmp2_sh_q     <= cmp2_sh_d;
      per_q         <= per_d;
      cmp1_q        <= cmp1_d;
      cmp2_q        <= cmp2_d;
      pending_q     <= pending_d;
      en_q          <= en_d;
      upnotdown_q   <= upnotdown_d;
      pwm_en_q      <= pwm_en_d;
      prescale_q    <= prescale_d;
      functions_q   <= functions_d;
      count_reset_q <= wr_cnt_rst;
      snap_q        <= snap_d;
    end
  end

`ifdef PWM_REGS_IRQ_EN
  logic [1:0] status_q, status_d, status_set, status_clr, mask_q, mask_d;

  always_comb begin
    status_set            = '0;
    status_set[ST_WRAP]   = upd;
    status_set[ST_LOADED] = xfer;
    status_clr            = (wr_en && offset == OFF_STATUS) ? wdata[1:0] : 2'b00;
    // Set wins over a same-cycle write-1-to-clear.
    status_d              = (status_q & ~status_clr) | status_set;
    mask_d                = (wr_en && offset == OFF_IRQ_MASK) ? wdata[1:0] : mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
    end
  end

  assign irq_req = |(status_q & mask_q);
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_PERIOD_L:  rdata = per16[7:0];
      OFF_PERIOD_H:  rdata = per16[15:8];
      OFF_EN:        rdata = {7'b0, en_q};
      OFF_CMP1_L:    rdata = cmp1_16[7:0];
      OFF_CMP1_H:    rdata = cmp1_16[15:8];
      OFF_CMP2_L:    rdata = cmp2_16[7:0];
      OFF_CMP2_H:    rdata = cmp2_16[15:8];
      OFF_COUNTER_L: rdata = cnt16[7:0];
      OFF_COUNTER_H: rdata = snap_q;
      OFF_PRESCALE:  rdata = prescale_q;
      OFF_UPNOTDOWN: rdata = {7'b0, upnotdown_q};
      OFF_PWM_EN:    rdata = {7'b0, pwm_en_q};
      OFF_FUNCTIONS: rdata = functions_q;
`ifdef PWM_REGS_IRQ_EN
      OFF_STATUS:    rdata = {6'b0, status_q};
      OFF_IRQ_MASK:  rdata = {6'b0, mask_q};
`endif
      default:       rdata = '0;
    endcase
  end

  assign period      = per_q;
  assign compare1    = cmp1_q;
  assign compare2    = cmp2_q;
  assign en          = en_q;
  assign count_reset = count_reset_q;
  assign upnotdown   = upnotdown_q;
  assign pwm_en      = pwm_en_q;
  assign prescale    = prescale_q;
  assign functions   = functions_q;

endmodule

// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register bank, NUM_CH channel register sets behind a byte-wide port.
// addr[7:4] selects the channel, addr[3:0] the register. Reads are registered with
// one cycle of latency. Optional interrupt logic is built when PWM_REGS_IRQ_EN is defined;
// otherwise irq is tied 0 and STATUS/IRQ_MASK read 0.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   read, write, addr, data_write   register access
//   data_read, rd_valid          registered read data and its valid pulse
//   upd, counter_val             per-channel wrap pulses and live counter values
//   period, compare1, compare2   active values, channel c at [c*CNT_W +: CNT_W]
//   en, count_reset, upnotdown, pwm_en   per-channel control bits
//   prescale, functions          per-channel bytes, channel c at [c*8 +: 8]
//   irq                          interrupt
module pwm_regs_mc
  import pwm_regs_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read,
  input  logic                    write,
  input  logic [7:0]              addr,
  input  logic [7:0]              data_write,
  output logic [7:0]              data_read,
  output logic                    rd_valid,
  input  logic [NUM_CH-1:0]       upd,
  input  logic [NUM_CH*CNT_W-1:0] counter_val,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       count_reset,
  output logic [NUM_CH-1:0]       upnotdown,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [NUM_CH*8-1:0]     prescale,
  output logic [NUM_CH*8-1:0]     functions,
  output logic                    irq
);

  logic [7:0] ch_rdata [NUM_CH];
  logic [7:0] rd_sel;
  logic [7:0] data_read_q;
  logic       rd_valid_q;
`ifdef PWM_REGS_IRQ_EN
  logic [NUM_CH-1:0] irq_req;
  logic              irq_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = (addr[7:4] == 4'(c));

    pwm_regs_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (write && sel),
      .rd_en       (read && sel),
      .offset      (addr[3:0]),
      .wdata       (data_write),
      .upd         (upd[c]),
      .counter_val (counter_val[c*CNT_W +: CNT_W]),
      .period      (period[c*CNT_W +: CNT_W]),
      .compare1    (compare1[c*CNT_W +: CNT_W]),
      .compare2    (compare2[c*CNT_W +: CNT_W]),
      .en          (en[c]),
      .count_reset (count_reset[c]),
      .upnotdown   (upnotdown[c]),
      .pwm_en      (pwm_en[c]),
      .prescale    (prescale[c*8 +: 8]),
      .functions   (functions[c*8 +: 8]),
`ifdef PWM_REGS_IRQ_EN
      .irq_req     (irq_req[c]),
`endif
      .rdata       (ch_rdata[c])
    );
  end

  // Channels >= NUM_CH match nothing and read 0.
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (addr[7:4] == 4'(c)) rd_sel = ch_rdata[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_read_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      data_read_q <= read ? rd_sel : 8'h00;
      rd_valid_q  <= read;
    end
  end

  assign data_read = data_read_q;
  assign rd_valid  = rd_valid_q;

`ifdef PWM_REGS_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |irq_req;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_regs_mc.sv
module tb_pwm_regs_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    read, write;
  logic [7:0]              addr, data_write, data_read;
  logic                    rd_valid;
  logic [NUM_CH-1:0]       upd;
  logic [NUM_CH*CNT_W-1:0] counter_val;
  logic [NUM_CH*CNT_W-1:0] period, compare1, compare2;
  logic [NUM_CH-1:0]       en, count_reset, upnotdown, pwm_en;
  logic [NUM_CH*8-1:0]     prescale, functions;
  logic                    irq;

  int checks   = 0;
  int failures = 0;

  pwm_regs_mc #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .data_write  (data_write),
    .data_read   (data_read),
    .rd_valid    (rd_valid),
    .upd         (upd),
    .counter_val (counter_val),
    .period      (period),
    .compare1    (compare1),
    .compare2    (compare2),
    .en          (en),
    .count_reset (count_reset),
    .upnotdown   (upnotdown),
    .pwm_en      (pwm_en),
    .prescale    (prescale),
    .functions   (functions),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    write = 1'b1; addr = a; data_write = d;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d);
    read = 1'b1; addr = a;
    tick();
    read = 1'b0;
    check("rd_valid_pulse", 64'(rd_valid), 64'd1);
    d = data_read;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [7:0] rd;

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; data_write = '0;
    upd = '0; counter_val = '0;
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_period", period, 64'd0);
    check("rst_upnotdown", 64'(upnotdown), 64'hF);
    check("rst_en", 64'(en), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);

    // Table: write then read back
    vecs[0]  = '{addr: 8'h00, wdata: 8'h34, exp: 8'h34};
    vecs[1]  = '{addr: 8'h01, wdata: 8'h12, exp: 8'h12};
    vecs[2]  = '{addr: 8'h02, wdata: 8'hFF, exp: 8'h01};
    vecs[3]  = '{addr: 8'h03, wdata: 8'hAA, exp: 8'hAA};
    vecs[4]  = '{addr: 8'h06, wdata: 8'h5A, exp: 8'h5A};
    vecs[5]  = '{addr: 8'h07, wdata: 8'h99, exp: 8'h00};
    vecs[6]  = '{addr: 8'h0A, wdata: 8'h07, exp: 8'h07};
    vecs[7]  = '{addr: 8'h0B, wdata: 8'h00, exp: 8'h00};
    vecs[8]  = '{addr: 8'h0C, wdata: 8'h03, exp: 8'h01};
    vecs[9]  = '{addr: 8'h0D, wdata: 8'hC3, exp: 8'hC3};
    vecs[10] = '{addr: 8'h50, wdata: 8'h11, exp: 8'h00};
    vecs[11] = '{addr: 8'h1A, wdata: 8'h22, exp: 8'h22};
    vecs[12] = '{addr: 8'h39, wdata: 8'h44, exp: 8'h00};
    for (int i = 0; i < 13; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata);
      do_read(vecs[i].addr, rd);
      check($sformatf("tbl_%0d_addr%02h", i, vecs[i].addr), 64'(rd), 64'(vecs[i].exp));
    end
    check("tbl_prescale", 64'(prescale), 64'h0000_2207);
    check("tbl_functions", 64'(functions), 64'h0000_00C3);
    check("tbl_pwm_en", 64'(pwm_en), 64'h1);
    check("tbl_upnotdown", 64'(upnotdown), 64'hE);
    tick();
    check("idle_rd_valid", 64'(rd_valid), 64'd0);
    check("idle_data_read", 64'(data_read), 64'd0);

    // Read and write same address same cycle: old value returned
    do_write(8'h0A, 8'h11);
    read = 1'b1; write = 1'b1; addr = 8'h0A; data_write = 8'h22;
    tick();
    read = 1'b0; write = 1'b0;
    check("rw_same_old", 64'(data_read), 64'h11);
    do_read(8'h0A, rd);
    check("rw_same_new", 64'(rd), 64'h22);

    // 1. Reset mid-traffic
    do_write(8'h0A, 8'h55);
    read = 1'b1; write = 1'b1; addr = 8'h0A; data_write = 8'h66;
    tick();
    read = 1'b1; write = 1'b1; addr = 8'h07;
    tick();
    read = 1'b0; write = 1'b0;
    check("pre_rst_count_reset", 64'(count_reset), 64'h1);
    check("pre_rst_rd_valid", 64'(rd_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_data_read", 64'(data_read), 64'd0);
    check("mid_rst_count_reset", 64'(count_reset), 64'd0);
    check("mid_rst_prescale", 64'(prescale), 64'd0);
    check("mid_rst_upnotdown", 64'(upnotdown), 64'hF);
    check("mid_rst_period", period, 64'd0);
    check("mid_rst_compare2", compare2, 64'd0);
    check("mid_rst_en_pwm", 64'({en, pwm_en}), 64'd0);
    tick();
    rst = 1'b0;
    do_read(8'h0A, rd);
    check("post_rst_read", 64'(rd), 64'h00);

    // 2. Double buffer: ch1 running, waits for upd
    do_reset();
    do_write(8'h12, 8'h01);
    do_write(8'h10, 8'h34);
    do_write(8'h11, 8'h12);
    tick();
    check("db_hold", period, 64'd0);
    upd = 4'b0010;
    tick();
    upd = '0;
    check("db_load_ch1", period, 64'h0000_0000_1234_0000);
    // ch2 stopped: loads the cycle after the write
    do_write(8'h20, 8'h78);
    check("db_stopped_same", period[47:32], 64'h0);
    tick();
    check("db_stopped_next", period, 64'h0000_0078_1234_0000);

    // 3. Collision of write and upd on ch0
    do_write(8'h02, 8'h01);
    do_write(8'h03, 8'h11);
    check("col_before", compare1[15:0], 64'h0);
    write = 1'b1; addr = 8'h03; data_write = 8'h55; upd = 4'b0001;
    tick();
    write = 1'b0; upd = '0;
    check("col_old_shadow", compare1[15:0], 64'h0011);
    tick();
    check("col_still_pending", compare1[15:0], 64'h0011);
    upd = 4'b0001;
    tick();
    upd = '0;
    check("col_new_shadow", compare1[15:0], 64'h0055);

    // 4. Counter snapshot on ch2
    counter_val[47:32] = 16'h00FF;
    do_read(8'h28, rd);
    check("snap_low", 64'(rd), 64'hFF);
    counter_val[47:32] = 16'h0100;
    do_read(8'h29, rd);
    check("snap_high", 64'(rd), 64'h00);
    counter_val[47:32] = 16'hABCD;
    do_read(8'h28, rd);
    check("snap_low2", 64'(rd), 64'hCD);
    counter_val[47:32] = 16'h1234;
    do_read(8'h29, rd);
    check("snap_high2", 64'(rd), 64'hAB);

    // 5. Count reset back-to-back, also forces transfer on running ch0
    do_write(8'h00, 8'h77);
    tick();
    check("cr_hold", period[15:0], 64'h0);
    write = 1'b1; addr = 8'h07; data_write = 8'h00;
    tick();
    check("cr_pulse1", 64'(count_reset), 64'h1);
    check("cr_forced_load", period[15:0], 64'h0077);
    tick();
    write = 1'b0;
    check("cr_pulse2", 64'(count_reset), 64'h1);
    tick();
    check("cr_end", 64'(count_reset), 64'h0);

    // 6. IRQ
    do_reset();
`ifdef PWM_REGS_IRQ_EN
    do_write(8'h3F, 8'h01);
    upd = 4'b1000;
    tick();
    upd = '0;
    do_read(8'h3E, rd);
    check("irq_status", 64'(rd), 64'h01);
    check("irq_high", 64'(irq), 64'd1);
    do_write(8'h3E, 8'h01);
    tick();
    check("irq_cleared", 64'(irq), 64'd0);
    do_read(8'h3E, rd);
    check("irq_status_clr", 64'(rd), 64'h00);
`else
    do_write(8'h3F, 8'h01);
    upd = 4'b1000;
    tick();
    upd = '0;
    do_read(8'h3E, rd);
    check("noirq_status", 64'(rd), 64'h00);
    check("noirq_irq1", 64'(irq), 64'd0);
    do_read(8'h3F, rd);
    check("noirq_mask", 64'(rd), 64'h00);
    tick();
    check("noirq_irq2", 64'(irq), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
